// File: rtl/stream_demux_pkg.sv
// Shared helpers for the 1-to-N stream demultiplexer.
// Combinational functions only, no state.
// No flow control of its own.
package stream_demux_pkg;

    // Select-to-onehot decoder; selects at or beyond n decode to all-zero
    function automatic logic [31:0] onehot_dec(input logic [4:0] sel, input int unsigned n);
        logic [31:0] dec;
        dec = '0;
        if (32'(sel) < n) begin
            dec[sel] = 1'b1;
        end
        return dec;
    endfunction

    // Increment that sticks at vmax instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
        return (v >= vmax) ? vmax : v + 32'd1;
    endfunction

endpackage

// File: rtl/stream_demux_1ton_if.sv
// Handshake bundle between the producer, the demux and its N consumers.
// Wires only, no latency.
// Carries s_ready and per-channel m_ready for backpressure.
interface stream_demux_1ton_if #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) ();
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_data;
    logic [SW-1:0]    s_sel;
    logic             s_bcast;
    logic [N-1:0]     m_valid;
    logic [N-1:0]     m_ready;
    logic [N*W-1:0]   m_data;

    // Demux view: consumes the input stream, produces N output streams
    modport slave (
        input  s_valid, s_data, s_sel, s_bcast, m_ready,
        output s_ready, m_valid, m_data
    );

    // Environment view: drives the input stream and the consumer readies
    modport master (
        output s_valid, s_data, s_sel, s_bcast, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/demux_out_slot.sv
// One output channel: a single-entry valid/data holding register.
// Written word appears on valid/dout one cycle after wr.
// Holds valid/dout stable while rdy is low; free allows same-cycle drain and refill.
module demux_out_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         rdy,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         free
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    // Next state: a write wins, a handshake empties, otherwise hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (wr) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (rdy) begin
            valid_d = 1'b0;
        end
    end

    // Holding register, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;
    // Empty now, or being drained at this edge
    assign free  = ~valid_q | rdy;

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demux with unicast/broadcast routing and drop accounting.
// Latency 1 cycle from input handshake to m_valid; drops pulse drop_pulse 1 cycle later.
// s_ready is low unless every targeted slot is free; untargeted words are always accepted.
module stream_demux_1ton
    import stream_demux_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stream_demux_1ton_if.slave   bus,
    input  logic [N-1:0]         en_mask,
    output logic                 drop_pulse,
    output logic [CW-1:0]        drop_cnt
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CW) - 64'd1);

    logic [31:0]   sel_dec;
    logic [N-1:0]  tgt;
    logic [N-1:0]  slot_free;
    logic [N-1:0]  slot_wr;
    logic          is_drop;
    logic          xfer;
    logic          drop_pulse_q, drop_pulse_d;
    logic [CW-1:0] drop_cnt_q,   drop_cnt_d;

    // Target set, acceptance and per-slot write strobes
    always_comb begin
        sel_dec     = onehot_dec(5'(bus.s_sel), 32'(N));
        tgt         = bus.s_bcast ? en_mask : (sel_dec[N-1:0] & en_mask);
        is_drop     = (tgt == '0);
        // All-or-nothing: a broadcast waits until every target can take it
        bus.s_ready = is_drop | (&(~tgt | slot_free));
        xfer        = bus.s_valid & bus.s_ready;
        slot_wr     = xfer ? tgt : '0;
    end

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_slot
            demux_out_slot #(.W(W)) u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .wr    (slot_wr[k]),
                .din   (bus.s_data),
                .rdy   (bus.m_ready[k]),
                .valid (bus.m_valid[k]),
                .dout  (bus.m_data[k*W +: W]),
                .free  (slot_free[k])
            );
        end
    endgenerate

    // Drop accounting next state: pulse on an accepted untargeted word, count saturates
    always_comb begin
        drop_pulse_d = xfer & is_drop;
        drop_cnt_d   = drop_cnt_q;
        if (xfer && is_drop) begin
            drop_cnt_d = CW'(sat_inc(32'(drop_cnt_q), CNT_MAX));
        end
    end

    // Drop accounting registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1toN

Overview:
- Parametrised, registered 1-to-N stream demultiplexer; successor to the combinational 1-to-4 and 1-to-8 demux cells.
- Routes a W-bit word with valid/ready handshake to one selected output channel (unicast), or to all enabled channels (broadcast).
- Each output channel has a one-deep holding register, so backpressure is per channel.
- Sits between a single producer and N consumer pipelines.

Parameters:
- N, 8, number of output channels (2..32; need not be a power of 2).
- W, 8, data width in bits.
- SW, $clog2(N), select width (derived; not overridden).
- CW, 8, width of the drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept the input word this cycle.
- s_data  in  W  input word.
- s_sel  in  SW  destination channel (unicast).
- s_bcast  in  1  1 = broadcast to every channel set in en_mask; s_sel is ignored.
- en_mask  in  N  channel enable; treated as quasi-static, sampled every cycle.
- m_valid  out  N  per-channel output valid.
- m_ready  in  N  per-channel consumer ready.
- m_data  out  N*W  channel k occupies bits [k*W +: W].
- drop_pulse  out  1  1-cycle pulse when an accepted word is discarded.
- drop_cnt  out  CW  saturating count of discarded words.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): m_valid=0, m_data=0, drop_pulse=0, drop_cnt=0. Reset mid-transfer discards all held words; no partial output.
- Slot k is "free" when ~m_valid[k] | m_ready[k], so drain and refill can happen in the same cycle.
- Target set T:
  - Unicast: T = onehot(s_sel) & en_mask.
  - Broadcast: T = en_mask.
- Drop condition: T == 0, caused by s_sel >= N, a disabled channel, or broadcast with en_mask == 0.
- s_ready, combinational, no dependence on s_valid:
  - Drop case: 1.
  - Otherwise: 1 only when every k in T is free. There are no partial broadcasts.
- Transfer occurs when s_valid & s_ready.
- On a transfer with T != 0, at the next edge:
  - For every k in T: m_valid[k]=1 and m_data[k]=s_data.
  - Channels not in T are unaffected.
  - Latency is exactly 1 cycle.
- On a transfer with T == 0:
  - No channel changes.
  - drop_pulse=1 for the next cycle.
  - drop_cnt increments and saturates at 2^CW-1.
- Channel k with m_valid[k] & m_ready[k] and no new write → m_valid[k]=0 next cycle.
- Channel k with m_valid[k] & ~m_ready[k] → m_valid[k] and m_data[k] hold stable. This is the AXI-stream style rule: valid is never withdrawn and data never changes while stalled.
- Clearing en_mask[k] does not flush a word already held in slot k; that word still drains normally.
- Throughput: 1 word/cycle per channel when consumers are always ready.
- No combinational path from m_ready to m_valid or m_data. The only combinational paths are to s_ready, from m_ready, en_mask, s_sel and s_bcast.

Decomposition:
- Shared package stream_demux_pkg holds:
  - onehot_dec function (SW → N decoder with out-of-range → 0).
  - A saturating-increment function.
  - No typedefs beyond these.
- Sub-module demux_out_slot: one channel's valid/data register. Ports: clk, rst_n, wr, din[W], rdy, valid, dout[W], free.
- The top instantiates N slots in a generate loop, plus the target, ready and drop logic.

Test Plan:
- Reset with N=8, W=8, en_mask=FF; release; unicast s_sel=3, s_data=A5, m_ready=FF → m_valid=08 and m_data[3]=A5 one cycle later; m_valid=00 the cycle after.
- Hold m_ready[3]=0; send two words 11 then 22 to ch3 → first is accepted; s_ready=0 on the second until m_ready[3]=1. m_data[3] stays 11 throughout the stall, then 22 follows the cycle after the drain.
- Drain-and-refill: ch2 full and m_ready[2]=1 in the same cycle as a new word 5A to ch2 → s_ready=1; m_valid[2] stays 1 and m_data[2]=5A. Continuous back-to-back at 1 word/cycle.
- Broadcast 3C with en_mask=0F, m_ready[1]=0 and ch1 full → s_ready=0 with no channel written. Raise m_ready[1] → all of ch0..3 get 3C together; ch4..7 untouched.
- Drops: N=6, unicast s_sel=7; then unicast to a disabled channel; then broadcast with en_mask=0 → s_ready=1 each time, three drop_pulses, drop_cnt=3. With CW=2, a fourth drop leaves drop_cnt=3 (saturated).
- Assert rst_n=0 asynchronously mid-cycle while channels hold data → m_valid=0 and drop_cnt=0 immediately, without waiting for a clock edge.
